sm4_masked_lin_update: RTL and testbench
========================================

Name: sm4_masked_lin_update

Overview:
- Masked SM4 round back-end that sits directly downstream of the masked S-box layer.
- Holds the 128-bit two-share round state (value share X, mask share M).
- Per round: issues the masked S-box input T to the upstream S-box layer, then takes the masked S-box outputs, applies the linear transform L to each share, and updates the state.
- Sequences all rounds and presents the final reversed ciphertext shares.

Parameters:
- ROUNDS, 32, number of rounds before completion (legal range 1..32).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- load  in  1  start a block; sampled only in IDLE.
- x_in  in  128  initial value share {X0,X1,X2,X3}, X0 in [127:96].
- xm_in  in  128  initial mask share {M0,M1,M2,M3}.
- rk_in  in  32  round key for round round_cnt; sampled in EMIT.
- sbox_done  in  1  S-box results valid, single-cycle pulse.
- s_in  in  32  masked S-box output, value share.
- sm_in  in  32  masked S-box output, mask share.
- t_out  out  32  X1^X2^X3^rk_in (value share to S-box).
- tm_out  out  32  M1^M2^M3 (mask share to S-box).
- t_valid  out  1  one-cycle pulse; t_out/tm_out are fresh.
- round_cnt  out  5  current round index, 0..ROUNDS-1.
- busy  out  1  high in every state except IDLE.
- state_out  out  128  final value share {X35,X34,X33,X32}.
- state_mask_out  out  128  final mask share, same ordering.
- done  out  1  one-cycle pulse; final outputs valid.

Behaviour:
- Reset (rst high at a clock edge): FSM to IDLE; all state, t_out, tm_out, state_out, state_mask_out = 0; round_cnt = 0; t_valid = done = busy = 0. Applies mid-operation too, aborting the block with no done pulse.
- FSM states: IDLE, EMIT, WAIT, FIN.
- IDLE: on load, capture x_in/xm_in, round_cnt <= 0, go to EMIT. If load is not asserted, stay.
- EMIT, lasting 1 cycle:
  - Register t_out = X1^X2^X3^rk_in and tm_out = M1^M2^M3.
  - Set t_valid <= 1 and go to WAIT.
  - t_valid is therefore high the cycle after EMIT and cleared on the following edge.
- WAIT: hold until sbox_done is sampled high. On that edge:
  - L(B) = B ^ rol(B,2) ^ rol(B,10) ^ rol(B,18) ^ rol(B,24).
  - New X = {X1,X2,X3, X0^L(s_in)}; new M = {M1,M2,M3, M0^L(sm_in)}.
  - If round_cnt == ROUNDS-1, go to FIN. Otherwise round_cnt++ and go to EMIT.
  - A sbox_done pulse coinciding with the t_valid cycle is legal and accepted.
- FIN, lasting 1 cycle:
  - state_out <= {X3,X2,X1,X0}; state_mask_out <= {M3,M2,M1,M0}.
  - done <= 1 for one cycle; go to IDLE; round_cnt <= 0.
  - state_out and state_mask_out hold until the next FIN or reset.
- Ignored inputs:
  - load outside IDLE has no effect.
  - sbox_done outside WAIT has no effect.
  - rk_in is only sampled in EMIT.
- Masking invariant: L is linear, so L(s)^L(sm) = L(s^sm). The XOR of the shares always equals the unmasked SM4 state. No share is ever combined with its own mask except as defined above.
- Latency per round: EMIT (1 cycle) + WAIT (≥1 cycle). Total latency is ROUNDS*(2+sbox latency) + 1 cycle for FIN.
- All arithmetic is 32-bit XOR and rotate; no carries.
- A done pulse and a new load may be accepted back-to-back: load is sampled in the IDLE cycle after FIN.

Test Plan:
- Reset: assert rst mid-round (round_cnt = 7) -> next cycle busy = 0, round_cnt = 0, all outputs 0; a later sbox_done produces no state change and no done pulse.
- Single-round L check: ROUNDS = 1, x_in = 0, xm_in = 0, sbox_done with s_in = 0x00000001 and sm_in = 0 -> state_out = {0x01040405, 0, 0, 0}, done one cycle after the update edge.
- Standard vector, unmasked: xm_in = 0, x_in = 0x0123456789ABCDEFFEDCBA9876543210, bench S-box model plus key-schedule rk (rk0 = 0xF12186F9, rk31 = 0x9124A012) -> state_out = 0x681EDF34D206965E86B3E94F536E4246; exactly 32 t_valid pulses and 1 done pulse.
- Masked: same vector, random xm_in, masked S-box model with random masks -> state_out ^ state_mask_out = 0x681EDF34D206965E86B3E94F536E4246, and state_out ≠ plaintext-derived ciphertext whenever the masks are nonzero.
- Handshake corners:
  - sbox_done on the t_valid cycle -> accepted.
  - sbox_done pulses in EMIT/IDLE -> ignored; round_cnt unchanged.
  - load while busy -> ignored.
- Back-to-back blocks: load in the cycle after done -> second block completes with correct result; first result stays stable until the second FIN.

Source files
------------

// File: rtl/sm4_masked_lin_update.sv
// rtl/sm4_masked_lin_update.sv - masked SM4 round back-end: linear layer, share update and round sequencing
module sm4_masked_lin_update #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] x_in,
    input  logic [127:0] xm_in,
    input  logic [31:0]  rk_in,
    input  logic         sbox_done,
    input  logic [31:0]  s_in,
    input  logic [31:0]  sm_in,
    output logic [31:0]  t_out,
    output logic [31:0]  tm_out,
    output logic         t_valid,
    output logic [4:0]   round_cnt,
    output logic         busy,
    output logic [127:0] state_out,
    output logic [127:0] state_mask_out,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, EMIT, WAIT, FIN} state_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    state_t state, state_nxt;

    logic [31:0] x0, x1, x2, x3;
    logic [31:0] m0, m1, m2, m3;

    // L is linear, so applying it to each share separately keeps the sharing intact.
    function automatic logic [31:0] lin_l(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = EMIT;
            EMIT: state_nxt = WAIT;
            WAIT: begin
                if (sbox_done) begin
                    state_nxt = (round_cnt == LAST_ROUND) ? FIN : EMIT;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            x0             <= '0;
            x1             <= '0;
            x2             <= '0;
            x3             <= '0;
            m0             <= '0;
            m1             <= '0;
            m2             <= '0;
            m3             <= '0;
            t_out          <= '0;
            tm_out         <= '0;
            t_valid        <= 1'b0;
            round_cnt      <= '0;
            state_out      <= '0;
            state_mask_out <= '0;
            done           <= 1'b0;
        end else begin
            t_valid <= (state == EMIT);
            done    <= (state == FIN);
            case (state)
                IDLE: begin
                    if (load) begin
                        {x0, x1, x2, x3} <= x_in;
                        {m0, m1, m2, m3} <= xm_in;
                        round_cnt        <= '0;
                    end
                end
                EMIT: begin
                    // The round key only joins the value share; the mask share is key-independent.
                    t_out  <= x1 ^ x2 ^ x3 ^ rk_in;
                    tm_out <= m1 ^ m2 ^ m3;
                end
                WAIT: begin
                    if (sbox_done) begin
                        {x0, x1, x2, x3} <= {x1, x2, x3, x0 ^ lin_l(s_in)};
                        {m0, m1, m2, m3} <= {m1, m2, m3, m0 ^ lin_l(sm_in)};
                        if (round_cnt != LAST_ROUND) begin
                            round_cnt <= round_cnt + 5'd1;
                        end
                    end
                end
                FIN: begin
                    state_out      <= {x3, x2, x1, x0};
                    state_mask_out <= {m3, m2, m1, m0};
                    round_cnt      <= '0;
                end
                default: begin
                    round_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_masked_lin_update.sv
// tb/tb_sm4_masked_lin_update.sv - randomized self-checking bench against an SM4 reference model
module tb_sm4_masked_lin_update;

    localparam logic [127:0] PT = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CT = 128'h681EDF34D206965E86B3E94F536E4246;

    logic         clk = 1'b0;
    logic         rst, load, load1, sbox_done;
    logic [127:0] x_in, xm_in;
    logic [31:0]  rk_in, s_in, sm_in;

    logic [31:0]  t_out, tm_out, t_out1, tm_out1;
    logic         t_valid, t_valid1, busy, busy1, done, done1;
    logic [4:0]   round_cnt, round_cnt1;
    logic [127:0] state_out, state_mask_out, state_out1, state_mask_out1;

    int checks = 0;
    int failures = 0;
    int tv_cnt = 0;
    int done_cnt = 0;

    logic [31:0]  rk_tab [32];
    logic [127:0] exp_out;

    logic [7:0] sbox_tab [0:255] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    sm4_masked_lin_update #(.ROUNDS(32)) dut (
        .clk(clk), .rst(rst), .load(load), .x_in(x_in), .xm_in(xm_in), .rk_in(rk_in),
        .sbox_done(sbox_done), .s_in(s_in), .sm_in(sm_in), .t_out(t_out), .tm_out(tm_out),
        .t_valid(t_valid), .round_cnt(round_cnt), .busy(busy), .state_out(state_out),
        .state_mask_out(state_mask_out), .done(done)
    );

    sm4_masked_lin_update #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .x_in(x_in), .xm_in(xm_in), .rk_in(rk_in),
        .sbox_done(sbox_done), .s_in(s_in), .sm_in(sm_in), .t_out(t_out1), .tm_out(tm_out1),
        .t_valid(t_valid1), .round_cnt(round_cnt1), .busy(busy1), .state_out(state_out1),
        .state_mask_out(state_mask_out1), .done(done1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (t_valid === 1'b1) tv_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [31:0] rol32(input logic [31:0] b, input int n);
        return (b << n) | (b >> (32 - n));
    endfunction

    function automatic logic [31:0] sm4_l(input logic [31:0] b);
        return b ^ rol32(b, 2) ^ rol32(b, 10) ^ rol32(b, 18) ^ rol32(b, 24);
    endfunction

    function automatic logic [31:0] sm4_lk(input logic [31:0] b);
        return b ^ rol32(b, 13) ^ rol32(b, 23);
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] b);
        return {sbox_tab[b[31:24]], sbox_tab[b[23:16]], sbox_tab[b[15:8]], sbox_tab[b[7:0]]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key_sched(input logic [127:0] key);
        logic [31:0] k [36];
        logic [31:0] ck;
        k[0] = key[127:96] ^ 32'hA3B1BAC6;
        k[1] = key[95:64]  ^ 32'h56AA3350;
        k[2] = key[63:32]  ^ 32'h677D9197;
        k[3] = key[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) begin
                ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            end
            k[i+4] = k[i] ^ sm4_lk(tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck));
            rk_tab[i] = k[i+4];
        end
    endtask

    // Plays the upstream S-box layer for one block and tracks the unmasked SM4 state and the mask share.
    task automatic run_block(input logic [127:0] x, input logic [127:0] xm, input bit masked,
                             input bit rand_lat, input bit inject, input int abort_at,
                             input bit hold_chk, input logic [127:0] hold_val);
        logic [31:0] mx [4];
        logic [31:0] mk [4];
        logic [31:0] tin, sv, r, nx, nm;
        logic [127:0] exp_ct, exp_mask;
        int lat, cnt;
        for (int j = 0; j < 4; j++) begin
            mx[j] = x[127 - 32*j -: 32] ^ xm[127 - 32*j -: 32];
            mk[j] = xm[127 - 32*j -: 32];
        end
        x_in = x; xm_in = xm; rk_in = rk_tab[0]; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_load: got %b want 1", busy); end
        for (int i = 0; i < 32; i++) begin
            cnt = 0;
            while (t_valid !== 1'b1 && cnt < 20) begin step(); cnt++; end
            checks++;
            if (t_valid !== 1'b1) begin
                failures++; $display("FAIL t_valid_timeout: round %0d no t_valid", i);
                return;
            end
            tin = mx[1] ^ mx[2] ^ mx[3] ^ rk_tab[i];
            checks++;
            if ((t_out ^ tm_out) !== tin) begin
                failures++; $display("FAIL t_unmasked r%0d: got %h want %h", i, t_out ^ tm_out, tin);
            end
            checks++;
            if (tm_out !== (mk[1] ^ mk[2] ^ mk[3])) begin
                failures++; $display("FAIL tm_out r%0d: got %h want %h", i, tm_out, mk[1] ^ mk[2] ^ mk[3]);
            end
            checks++;
            if (round_cnt !== 5'(i)) begin
                failures++; $display("FAIL round_cnt: got %0d want %0d", round_cnt, i);
            end
            if (hold_chk) begin
                checks++;
                if (state_out !== hold_val) begin
                    failures++; $display("FAIL hold_out r%0d: got %h want %h", i, state_out, hold_val);
                end
            end
            if (i == abort_at) return;
            sv  = tau(tin);
            r   = masked ? $urandom : 32'h0;
            lat = rand_lat ? $urandom_range(0, 3) : 0;
            repeat (lat) step();
            s_in = sv ^ r; sm_in = r; sbox_done = 1'b1;
            step();
            sbox_done = 1'b0;
            nx = mx[0] ^ sm4_l(sv);
            nm = mk[0] ^ sm4_l(r);
            mx[0] = mx[1]; mx[1] = mx[2]; mx[2] = mx[3]; mx[3] = nx;
            mk[0] = mk[1]; mk[1] = mk[2]; mk[2] = mk[3]; mk[3] = nm;
            if (i < 31) rk_in = rk_tab[i+1];
            if (inject && i < 31) begin
                sbox_done = 1'b1; load = 1'b1; x_in = rand128(); s_in = $urandom;
                step();
                sbox_done = 1'b0; load = 1'b0;
            end
        end
        exp_ct   = {mx[3], mx[2], mx[1], mx[0]};
        exp_mask = {mk[3], mk[2], mk[1], mk[0]};
        exp_out  = exp_ct ^ exp_mask;
        if (hold_chk) begin
            checks++;
            if (state_out !== hold_val) begin
                failures++; $display("FAIL hold_out_fin: got %h want %h", state_out, hold_val);
            end
        end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_early: got %b want 0", done); end
        step();
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL done_pulse: got %b want 1", done); end
        checks++;
        if (state_mask_out !== exp_mask) begin
            failures++; $display("FAIL mask_out: got %h want %h", state_mask_out, exp_mask);
        end
        checks++;
        if ((state_out ^ state_mask_out) !== exp_ct) begin
            failures++; $display("FAIL unmasked_out: got %h want %h", state_out ^ state_mask_out, exp_ct);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({busy, t_valid, done, round_cnt, t_out, tm_out} !== '0 || state_out !== '0 || state_mask_out !== '0) begin
            failures++; $display("FAIL reset_state: busy=%b tv=%b done=%b rc=%0d out=%h", busy, t_valid, done, round_cnt, state_out);
        end
    endtask

    task automatic test_single_round();
        x_in = '0; xm_in = '0; rk_in = '0; load1 = 1'b1;
        step();
        load1 = 1'b0;
        step();
        checks++;
        if (t_valid1 !== 1'b1 || t_out1 !== 32'h0) begin
            failures++; $display("FAIL r1_t_valid: tv=%b t_out=%h want 1/0", t_valid1, t_out1);
        end
        s_in = 32'h00000001; sm_in = '0; sbox_done = 1'b1;
        step();
        sbox_done = 1'b0;
        checks++;
        if (done1 !== 1'b0) begin failures++; $display("FAIL r1_done_early: got %b want 0", done1); end
        step();
        checks++;
        if (done1 !== 1'b1) begin failures++; $display("FAIL r1_done: got %b want 1", done1); end
        checks++;
        if (state_out1 !== {32'h01040405, 96'h0} || state_mask_out1 !== '0) begin
            failures++; $display("FAIL r1_state_out: got %h want %h", state_out1, {32'h01040405, 96'h0});
        end
        step();
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            failures++; $display("FAIL r1_idle: done=%b busy=%b want 0/0", done1, busy1);
        end
    endtask

    task automatic test_unmasked();
        int tv0, dn0;
        tv0 = tv_cnt; dn0 = done_cnt;
        run_block(PT, '0, 1'b0, 1'b0, 1'b0, -1, 1'b0, '0);
        checks++;
        if (state_out !== CT) begin failures++; $display("FAIL std_vector: got %h want %h", state_out, CT); end
        step();
        checks++;
        if (tv_cnt - tv0 != 32 || done_cnt - dn0 != 1) begin
            failures++; $display("FAIL pulse_counts: t_valid=%0d done=%0d want 32/1", tv_cnt - tv0, done_cnt - dn0);
        end
    endtask

    task automatic test_masked();
        logic [127:0] xm;
        xm = rand128() | 128'h1;
        run_block(PT ^ xm, xm, 1'b1, 1'b1, 1'b0, -1, 1'b0, '0);
        checks++;
        if ((state_out ^ state_mask_out) !== CT) begin
            failures++; $display("FAIL masked_vector: got %h want %h", state_out ^ state_mask_out, CT);
        end
        checks++;
        if (state_out !== exp_out || state_out === CT) begin
            failures++; $display("FAIL masked_share: got %h want %h (not equal to ciphertext)", state_out, exp_out);
        end
        step();
    endtask

    task automatic test_handshake();
        logic [127:0] prev, xm;
        prev = state_out;
        sbox_done = 1'b1; s_in = $urandom;
        step(); step();
        sbox_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || round_cnt !== 5'd0 || done !== 1'b0 || state_out !== prev) begin
            failures++; $display("FAIL idle_sbox_done: busy=%b rc=%0d done=%b out=%h want 0/0/0/%h", busy, round_cnt, done, state_out, prev);
        end
        xm = rand128();
        run_block(PT ^ xm, xm, 1'b1, 1'b0, 1'b1, -1, 1'b0, '0);
        checks++;
        if ((state_out ^ state_mask_out) !== CT) begin
            failures++; $display("FAIL handshake_vector: got %h want %h", state_out ^ state_mask_out, CT);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] first;
        run_block(rand128(), rand128(), 1'b1, 1'b1, 1'b0, -1, 1'b0, '0);
        first = exp_out;
        run_block(rand128(), rand128(), 1'b1, 1'b1, 1'b0, -1, 1'b1, first);
        checks++;
        if (state_out !== exp_out) begin
            failures++; $display("FAIL b2b_second: got %h want %h", state_out, exp_out);
        end
        step();
    endtask

    task automatic test_reset_mid_round();
        int dn0;
        run_block(rand128(), rand128(), 1'b1, 1'b0, 1'b0, 7, 1'b0, '0);
        dn0 = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({busy, t_valid, done, round_cnt, t_out, tm_out} !== '0 || state_out !== '0 || state_mask_out !== '0) begin
            failures++; $display("FAIL mid_reset: busy=%b tv=%b done=%b rc=%0d out=%h", busy, t_valid, done, round_cnt, state_out);
        end
        sbox_done = 1'b1; s_in = $urandom; sm_in = $urandom;
        step();
        sbox_done = 1'b0;
        repeat (4) step();
        checks++;
        if (done_cnt != dn0 || busy !== 1'b0 || state_out !== '0 || round_cnt !== 5'd0) begin
            failures++; $display("FAIL post_reset_idle: dones=%0d busy=%b out=%h want 0/0/0", done_cnt - dn0, busy, state_out);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load1 = 1'b0; sbox_done = 1'b0;
        x_in = '0; xm_in = '0; rk_in = '0; s_in = '0; sm_in = '0;
        key_sched(PT);
        test_reset();
        test_single_round();
        test_unmasked();
        test_masked();
        test_handshake();
        test_back_to_back();
        test_reset_mid_round();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
